// File: rtl/pad_data_gen_if.sv
// pad_data_gen_if -- control and frame bus for pad_data_gen.
//   master : drives the run configuration and enable, observes frames and status.
//   slave  : the generator; samples configuration, emits frames and status.
// Signals:
//   enable          start/continue generation, low aborts
//   mode            00 walking-one, 01 fixed, 10 PRBS, 11 walking-one
//   fixed_pattern   hit bits used in fixed mode
//   hit_period      hit frame every hit_period+1 BCs
//   frame_count     hit frames to send, 0 = unlimited
//   pad_data_out    [115:104] BCID, [103:0] hit bits
//   pad_data_valid  one-cycle strobe per frame
//   busy / done     SYNC-or-RUN / DONE indicators
//   hit_frames_sent saturating count of nonzero hit frames
//   gen_state       IDLE=0, SYNC=1, RUN=2, DONE=3
interface pad_data_gen_if;
   logic          enable;
   logic [1:0]    mode;
   logic [103:0]  fixed_pattern;
   logic [7:0]    hit_period;
   logic [15:0]   frame_count;
   logic [115:0]  pad_data_out;
   logic          pad_data_valid;
   logic          busy;
   logic          done;
   logic [15:0]   hit_frames_sent;
   logic [1:0]    gen_state;

   modport master (
      output enable, mode, fixed_pattern, hit_period, frame_count,
      input  pad_data_out, pad_data_valid, busy, done, hit_frames_sent, gen_state
   );

   modport slave (
      input  enable, mode, fixed_pattern, hit_period, frame_count,
      output pad_data_out, pad_data_valid, busy, done, hit_frames_sent, gen_state
   );
endinterface

// File: rtl/pad_data_gen.sv
// pad_data_gen -- pad trigger data frame generator.
// Emits one 116-bit frame per bunch crossing (every CLK_PER_BC clk160 cycles):
// SYNC_BCS empty sync frames, then hit frames every hit_period+1 BCs carrying
// a walking-one, fixed or PRBS pattern, until frame_count nonzero hit frames
// have gone out (frame_count = 0 runs forever).
// Ports:
//   clk160  sole clock, rising edge
//   reset   synchronous, active-high
//   bus     pad_data_gen_if.slave (configuration in, frames and status out)
// Configuration macro:
//   PAD_DATA_GEN_PRBS_EN  builds the 31-bit LFSR for mode 10; when undefined
//                         mode 10 falls back to walking-one.
module pad_data_gen #(
   parameter int CLK_PER_BC = 4,
   parameter int BCID_MAX   = 3563,
   parameter int SYNC_BCS   = 16
) (
   input  logic          clk160,
   input  logic          reset,
   pad_data_gen_if.slave bus
);
   localparam int BCW = $clog2(CLK_PER_BC + 1);
   localparam int SCW = $clog2(SYNC_BCS + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;
   state_t state_q, state_d;

   logic [BCW-1:0] bc_cnt;
   logic [SCW-1:0] sync_cnt;
   logic [7:0]     hp_cnt;
   logic [11:0]    bcid;
   logic [6:0]     walk;
   logic [15:0]    hit_cnt;
   logic [1:0]     mode_l;
   logic [103:0]   fixed_l;
   logic [7:0]     hp_l;
   logic [15:0]    fc_l;
   logic [115:0]   data_q;
   logic           valid_q;
   logic           start, bc_strobe, reached, emit, hit_slot;
   logic [103:0]   pattern, hits;
`ifdef PAD_DATA_GEN_PRBS_EN
   logic [30:0]    prbs;
   logic [31:0]    prbs32;
   assign prbs32 = {1'b0, prbs};
`endif

   assign start     = (state_q == IDLE) && bus.enable;
   assign bc_strobe = (bc_cnt == BCW'(CLK_PER_BC - 1));
   assign reached   = (fc_l != 16'd0) && (hit_cnt == fc_l);
   // A frame goes out on the BC strobe only while enabled; once the last hit
   // frame is counted no further frame is emitted before entering DONE.
   assign emit      = bc_strobe && bus.enable &&
                      ((state_q == SYNC) || ((state_q == RUN) && !reached));
   assign hit_slot  = (state_q == RUN) && (hp_cnt == 8'd0);

   always_comb begin
      pattern = 104'd1 << walk;
      case (mode_l)
         2'b01:   pattern = fixed_l;
`ifdef PAD_DATA_GEN_PRBS_EN
         2'b10:   pattern = {prbs32[7:0], prbs32, prbs32, prbs32};
`endif
         default: ;
      endcase
   end

   assign hits = hit_slot ? pattern : 104'd0;

   always_ff @(posedge clk160) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.enable) state_d = SYNC;
         SYNC: if (!bus.enable) state_d = IDLE;
               else if (emit && sync_cnt == SCW'(SYNC_BCS - 1)) state_d = RUN;
         RUN:  if (!bus.enable) state_d = IDLE;
               else if (reached) state_d = DONE;
         DONE: if (!bus.enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk160) begin
      if (reset) begin
         bc_cnt   <= '0;
         sync_cnt <= '0;
         hp_cnt   <= '0;
         bcid     <= '0;
         walk     <= '0;
         hit_cnt  <= '0;
         mode_l   <= '0;
         fixed_l  <= '0;
         hp_l     <= '0;
         fc_l     <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
`ifdef PAD_DATA_GEN_PRBS_EN
         prbs     <= 31'h1;
`endif
      end else begin
         valid_q <= emit;
         if (start) begin
            // Configuration is frozen for the whole run.
            mode_l   <= bus.mode;
            fixed_l  <= bus.fixed_pattern;
            hp_l     <= bus.hit_period;
            fc_l     <= bus.frame_count;
            bc_cnt   <= '0;
            sync_cnt <= '0;
            hp_cnt   <= '0;
            bcid     <= '0;
            walk     <= '0;
            hit_cnt  <= '0;
`ifdef PAD_DATA_GEN_PRBS_EN
            prbs     <= 31'h1;
`endif
         end else begin
            bc_cnt <= bc_strobe ? '0 : bc_cnt + BCW'(1);
            if (emit) begin
               data_q <= {bcid, hits};
               bcid   <= (bcid == 12'(BCID_MAX)) ? 12'd0 : bcid + 12'd1;
               if (state_q == SYNC) sync_cnt <= sync_cnt + SCW'(1);
               if (state_q == RUN)  hp_cnt <= (hp_cnt == hp_l) ? 8'd0 : hp_cnt + 8'd1;
               if (hit_slot) begin
                  walk <= (walk == 7'd103) ? 7'd0 : walk + 7'd1;
`ifdef PAD_DATA_GEN_PRBS_EN
                  // x^31 + x^28 + 1, stepped after the frame used the current value
                  prbs <= {prbs[29:0], prbs[30] ^ prbs[27]};
`endif
                  if (hits != 104'd0 && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
               end
            end
         end
      end
   end

   assign bus.pad_data_out    = data_q;
   assign bus.pad_data_valid  = valid_q;
   assign bus.busy            = (state_q == SYNC) || (state_q == RUN);
   assign bus.done            = (state_q == DONE);
   assign bus.hit_frames_sent = hit_cnt;
   assign bus.gen_state       = state_q;
endmodule

// File: doc/pad_data_gen.md
PAD_DATA_GEN -- requirements
Module: pad_data_gen

Interface
REQ-001 SHALL have parameter CLK_PER_BC, default 4, clk160 cycles per bunch crossing (BC).
REQ-002 SHALL have parameter BCID_MAX, default 3563, last BCID value before wrap to 0.
REQ-003 SHALL have parameter SYNC_BCS, default 16, number of empty sync frames sent before hit frames.
REQ-004 SHALL have port clk160  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  in  1  start/continue generation; low aborts.
REQ-007 SHALL have port mode  in  2  hit pattern: 00 walking-one, 01 fixed, 10 PRBS, 11 treated as 00.
REQ-008 SHALL have port fixed_pattern  in  104  hit bits for mode 01.
REQ-009 SHALL have port hit_period  in  8  hit frame every hit_period+1 BCs.
REQ-010 SHALL have port frame_count  in  16  hit frames to send; 0 = unlimited.
REQ-011 SHALL have port pad_data_out  out  116  frame: [115:104] BCID, [103:0] hit bits.
REQ-012 SHALL have port pad_data_valid  out  1  one-cycle strobe per emitted frame.
REQ-013 SHALL have port busy  out  1  high in SYNC or RUN.
REQ-014 SHALL have port done  out  1  high in DONE.
REQ-015 SHALL have port hit_frames_sent  out  16  count of nonzero-pattern frames emitted, saturating at 16'hFFFF.
REQ-016 SHALL have port gen_state  out  2  IDLE=0, SYNC=1, RUN=2, DONE=3.

Function
REQ-017 SHALL generate a BC strobe once every CLK_PER_BC cycles from a free-running counter cleared on entering SYNC.
REQ-018 SHALL assert pad_data_valid for exactly one cycle per BC strobe while in SYNC or RUN, never otherwise; pad_data_out registered, same cycle as valid.
REQ-019 SHALL increment BCID by 1 on each emitted frame, wrapping BCID_MAX -> 0; BCID is 0 on the first SYNC frame.
REQ-020 SHALL latch mode, fixed_pattern, hit_period, frame_count on IDLE->SYNC; changes during SYNC/RUN are ignored.
REQ-021 SHALL transition IDLE->SYNC on the cycle enable is sampled high.
REQ-022 SHALL emit SYNC_BCS frames with hit bits all zero in SYNC, then go to RUN.
REQ-023 SHALL in RUN emit the pattern frame on BC index 0 modulo hit_period+1 (first RUN frame is a hit frame), else all-zero hit bits.
REQ-024 SHALL advance walking-one position 0..103 after each hit frame, wrapping 103 -> 0; first hit frame has bit 0 set.
REQ-025 SHALL count a hit frame in hit_frames_sent only if its hit bits are nonzero (fixed_pattern zero counts nothing and never reaches DONE unless frame_count=0 is treated as unlimited).
REQ-026 SHALL go RUN->DONE on the cycle after the hit frame bringing hit_frames_sent equal to nonzero frame_count; no further valid strobes.
REQ-027 SHALL go DONE->IDLE when enable is low.
REQ-028 SHALL go from SYNC or RUN to IDLE the cycle after enable is sampled low; no valid strobe in the abort cycle or after.
REQ-029 SHALL clear hit_frames_sent, BCID, walking position on IDLE->SYNC; hit_frames_sent holds its value in DONE and IDLE.

Reset
REQ-030 SHALL on reset force gen_state IDLE, pad_data_out 0, pad_data_valid 0, busy 0, done 0, hit_frames_sent 0, BCID 0, PRBS register 31'h1; reset wins over enable in the same cycle.
REQ-031 SHALL, on reset asserted mid-frame, produce no valid strobe in the following cycle.

Configuration
REQ-032 SHALL compile PRBS mode only when PAD_DATA_GEN_PRBS_EN is defined: 31-bit LFSR x^31+x^28+1, seed 31'h1, stepped once per hit frame, hit bits = {L[7:0],L,L,L} using the pre-step value.
REQ-033 SHALL, without PAD_DATA_GEN_PRBS_EN, omit the LFSR and treat mode 10 as 00.

Verification
REQ-034 SHALL test: reset, enable=1, mode=00, hit_period=0, frame_count=3 -> 16 zero frames BCID 0..15, then hits 0x1,0x2,0x4 at BCID 16..18, done=1, hit_frames_sent=3.
REQ-035 SHALL test: valid spacing -> exactly 4 cycles between strobes with CLK_PER_BC=4.
REQ-036 SHALL test: frame_count=0, run >3564 frames -> BCID 3563 followed by 0, no DONE.
REQ-037 SHALL test: hit_period=2, mode=01, fixed_pattern=104'hA5 -> RUN frames pattern,0,0,pattern...; pattern frames have [103:0]=104'hA5.
REQ-038 SHALL test: enable dropped mid-RUN -> gen_state 0 next cycle, no further pad_data_valid.
REQ-039 SHALL test: with PAD_DATA_GEN_PRBS_EN, mode=10 -> first hit frame hit bits {8'h01,32'h1,32'h1,32'h1}; without the macro, same stimulus yields walking-one.
